pong_game_pixel_gen: RTL and testbench
======================================

Name: pong_game_pixel_gen

Overview:
- Sits directly downstream of the VGA timing counter and consumes its video_on, hsync, vsync and x/y pixel position.
- Holds all Pong game state: two paddles, ball position and direction, scores, and a serve/play/over state machine.
- Game state advances once per frame.
- Produces a registered 12-bit RGB pixel, plus hsync/vsync delayed by the same one cycle, for the board's VGA pins.

Parameters:
- HD, 640, visible width
- VD, 480, visible height
- PADDLE_H, 72, paddle height in pixels
- PADDLE_W, 4, paddle width in pixels
- PL_X, 32, left paddle leftmost column
- PR_X, 604, right paddle leftmost column
- PADDLE_V, 4, paddle step per frame
- BALL_SZ, 8, ball square size
- BALL_V, 2, ball step per frame on each axis
- SERVE_FRAMES, 60, frames the ball waits before a serve
- WIN_SCORE, 9, score that ends the game

Ports:
- clk_25MHz  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- video_on  in  1  pixel is in the visible area
- hsync_in  in  1  horizontal sync from the timing block
- vsync_in  in  1  vertical sync from the timing block
- x  in  10  pixel column, 0-799
- y  in  10  pixel row, 0-524
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  asynchronous paddle buttons
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}, registered
- hsync_out, vsync_out  out  1 each  hsync_in/vsync_in delayed 1 cycle
- score_l, score_r  out  4 each  player scores, 0..WIN_SCORE
- game_over  out  1  high in OVER

Behaviour:
- Clock and reset: all flops on clk_25MHz, asynchronous reset.
- Reset values:
  - rgb = 0; hsync_out = vsync_out = 1.
  - score_l = score_r = 0; game_over = 0.
  - Paddle tops pl_y = pr_y = 204.
  - ball_x = 316, ball_y = 236; dx = +, dy = +.
  - state = SERVE; serve counter = 0.
- Buttons: each goes through a 2-flop synchronizer.
- Frame tick: one-cycle pulse when x==0 && y==VD. All game state updates happen only on the tick.
- Paddles (all states except OVER):
  - On tick, up moves top -= PADDLE_V, clamped at 0.
  - down moves top += PADDLE_V, clamped at VD-PADDLE_H (408).
  - up and down both asserted: no move.
  - Clamp arithmetic uses an 11-bit intermediate; there is no underflow wrap.
- SERVE:
  - Ball held at (316,236).
  - Counter increments per tick.
  - At SERVE_FRAMES-1 the counter clears and state goes to PLAY.
- PLAY, per tick, directions are resolved first from the current position, then the ball moves BALL_V along the new dx/dy.
  - Top wall: ball_y <= BALL_V, so dy becomes +.
  - Bottom wall: ball_y+BALL_SZ >= VD-BALL_V, so dy becomes -.
  - Left hit: dx is -, ball_x <= PL_X+PADDLE_W, ball_x+BALL_SZ > PL_X, and rows overlap (ball_y+BALL_SZ > pl_y && ball_y < pl_y+PADDLE_H). Result: dx becomes +.
  - Right hit: mirror of left hit against PR_X and pr_y; dx becomes -.
  - Left miss: dx is -, no hit, and ball_x <= BALL_V.
    - score_r increments.
    - Ball resets to centre with dx = - (towards the loser).
    - State goes to SERVE.
  - Right miss: mirror of left miss, with threshold ball_x+BALL_SZ >= HD-BALL_V. score_l increments; ball resets with dx = +.
  - Hit takes priority over miss in the same tick.
  - A wall bounce and a paddle hit in the same tick both apply.
- OVER:
  - Entered when an increment makes either score equal WIN_SCORE. game_over becomes 1.
  - Ball is held at centre and paddles freeze.
  - Only reset leaves OVER.
- Pixel path:
  - One-cycle latency: rgb, hsync_out and vsync_out register together.
  - Colour priority: video_on==0 gives 0; ball gives FFF; left paddle gives 0F0; right paddle gives 00F; everything else gives 000.
  - Hit test: ball_x <= x < ball_x+BALL_SZ and the same on y; paddles use the same form with their width/height.
- Reset mid-frame: everything returns to reset values at once; the next tick is the first to act.

Decomposition:
- Package pong_pkg holds:
  - State enum SERVE/PLAY/OVER.
  - Geometry constants HD, VD, PL_X, PR_X, PADDLE_*, BALL_*.
  - Colour constants.
- Sub-module pong_paddle: synchronizer, clamp and register, instantiated twice.

Test Plan:
- Reset, then first tick: pl_y = pr_y = 204, ball at (316,236), state SERVE, rgb = 0. The 60th tick enters PLAY; the next tick puts the ball at (318,238).
- btn_l_up held 60 ticks: pl_y reaches 0 after 51 ticks and stays 0. btn_r_dn held: pr_y saturates at 408. Both buttons held: no move.
- Ball forced to dy=- at ball_y=2: the next tick gives dy=+ and ball_y=4.
- Left paddle at 200, ball at (36,220) with dx=-: dx becomes +, ball_x = 38, scores unchanged.
- Left paddle at 0, ball at (2,300) with dx=-: score_r = 1, ball at centre, dx=-, state SERVE.
- score_l = 8, then a right miss: score_l = 9, game_over = 1. Buttons are then ignored until reset. Pixel check: x=ball_x, y=ball_y with video_on gives rgb = FFF one cycle later, with hsync_out aligned.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types, geometry and colours for the Pong pixel generator.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  // Screen and object geometry, in pixels.
  localparam int HD           = 640;
  localparam int VD           = 480;
  localparam int PADDLE_H     = 72;
  localparam int PADDLE_W     = 4;
  localparam int PL_X         = 32;
  localparam int PR_X         = 604;
  localparam int PADDLE_V     = 4;
  localparam int BALL_SZ      = 8;
  localparam int BALL_V       = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 9;

  // Start positions: ball centred, paddles vertically centred.
  localparam logic [9:0] BALL_X0   = 10'((HD - BALL_SZ) / 2);
  localparam logic [9:0] BALL_Y0   = 10'((VD - BALL_SZ) / 2);
  localparam logic [9:0] PADDLE_Y0 = 10'((VD - PADDLE_H) / 2);

  // 12-bit colours {R,G,B}.
  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_BALL  = 12'hFFF;
  localparam logic [11:0] COL_LEFT  = 12'h0F0;
  localparam logic [11:0] COL_RIGHT = 12'h00F;

  // True when lo <= p < lo + len, evaluated in 11 bits so the upper bound cannot wrap.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo,
                                   input logic [10:0] len);
    return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + len));
  endfunction

endpackage

// File: rtl/pong_game_pixel_gen_paddle.sv
// One paddle: button synchronizers plus a clamped top-row register stepped once per frame.
module pong_paddle
  import pong_pkg::*;
(
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [9:0] top
);

  logic [1:0]  up_sync;
  logic [1:0]  dn_sync;
  logic        up;
  logic        dn;
  logic [10:0] top_ext;
  logic [10:0] up_val;
  logic [10:0] dn_val;
  logic [10:0] top_next;

  // Two-flop synchronizers for the asynchronous buttons.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_dn};
    end
  end

  assign up = up_sync[1];
  assign dn = dn_sync[1];

  // Candidate next top row, saturating at both screen edges; opposing buttons cancel.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    top_ext  = {1'b0, top};
    up_val   = (top_ext >= 11'(PADDLE_V)) ? top_ext - 11'(PADDLE_V) : 11'd0;
    dn_val   = (top_ext + 11'(PADDLE_V) <= 11'(VD - PADDLE_H))
               ? top_ext + 11'(PADDLE_V) : 11'(VD - PADDLE_H);
    top_next = top_ext;
    if (up && !dn)      top_next = up_val;
    else if (dn && !up) top_next = dn_val;
  end

  // Paddle position register, advanced only on the frame tick while play is allowed.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset)               top <= PADDLE_Y0;
    else if (tick && enable) top <= top_next[9:0];
  end

endmodule

// File: rtl/pong_game_pixel_gen.sv
// Pong game state and pixel colouring, one pixel-clock stage behind the VGA timing counter.
module pong_game_pixel_gen
  import pong_pkg::*;
(
  input  logic        clk_25MHz,
  input  logic        reset,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_l_up,
  input  logic        btn_l_dn,
  input  logic        btn_r_up,
  input  logic        btn_r_dn,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  state_t      state;
  logic [5:0]  serve_cnt;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic        dx;          // 1 = moving right
  logic        dy;          // 1 = moving down
  logic [9:0]  pl_y;
  logic [9:0]  pr_y;
  logic        tick;

  logic [10:0] bx, by, ply, pry;
  logic        top_wall, bot_wall;
  logic        left_hit, right_hit, left_miss, right_miss;
  logic        dx_n, dy_n;
  logic [9:0]  bx_n, by_n;
  logic        ball_on, lp_on, rp_on;
  logic [11:0] pix;

  // First pixel of the first blanked line: one pulse per frame.
  assign tick = (x == 10'd0) && (y == 10'(VD));

  pong_paddle u_left (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .tick      (tick),
    .enable    (state != OVER),
    .btn_up    (btn_l_up),
    .btn_dn    (btn_l_dn),
    .top       (pl_y)
  );

  pong_paddle u_right (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .tick      (tick),
    .enable    (state != OVER),
    .btn_up    (btn_r_up),
    .btn_dn    (btn_r_dn),
    .top       (pr_y)
  );

  // Collision resolution from the current position, then the stepped position along the new direction.
  always_comb begin
    bx  = {1'b0, ball_x};
    by  = {1'b0, ball_y};
    ply = {1'b0, pl_y};
    pry = {1'b0, pr_y};

    top_wall = (by <= 11'(BALL_V));
    bot_wall = (by + 11'(BALL_SZ) >= 11'(VD - BALL_V));
    dy_n = dy;
    if (top_wall)      dy_n = 1'b1;
    else if (bot_wall) dy_n = 1'b0;

    left_hit  = !dx && (bx <= 11'(PL_X + PADDLE_W)) && (bx + 11'(BALL_SZ) > 11'(PL_X))
                && (by + 11'(BALL_SZ) > ply) && (by < ply + 11'(PADDLE_H));
    right_hit = dx && (bx + 11'(BALL_SZ) >= 11'(PR_X)) && (bx < 11'(PR_X + PADDLE_W))
                && (by + 11'(BALL_SZ) > pry) && (by < pry + 11'(PADDLE_H));
    left_miss  = !dx && !left_hit && (bx <= 11'(BALL_V));
    right_miss = dx && !right_hit && (bx + 11'(BALL_SZ) >= 11'(HD - BALL_V));

    dx_n = dx;
    if (left_hit)       dx_n = 1'b1;
    else if (right_hit) dx_n = 1'b0;

    bx_n = dx_n ? ball_x + 10'(BALL_V) : ball_x - 10'(BALL_V);
    by_n = dy_n ? ball_y + 10'(BALL_V) : ball_y - 10'(BALL_V);
  end

  // Game FSM: serve countdown, ball flight and scoring, terminal OVER.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state     <= SERVE;
      serve_cnt <= '0;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
    end else if (tick) begin
      case (state)
        SERVE: begin
          ball_x <= BALL_X0;
          ball_y <= BALL_Y0;
          if (serve_cnt == 6'(SERVE_FRAMES - 1)) begin
            serve_cnt <= '0;
            state     <= PLAY;
          end else begin
            serve_cnt <= serve_cnt + 6'd1;
          end
        end
        PLAY: begin
          if (left_miss) begin
            score_r <= score_r + 4'd1;
            ball_x  <= BALL_X0;
            ball_y  <= BALL_Y0;
            dx      <= 1'b0;
            dy      <= dy_n;
            if (score_r == 4'(WIN_SCORE - 1)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end else if (right_miss) begin
            score_l <= score_l + 4'd1;
            ball_x  <= BALL_X0;
            ball_y  <= BALL_Y0;
            dx      <= 1'b1;
            dy      <= dy_n;
            if (score_l == 4'(WIN_SCORE - 1)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= SERVE;
            end
          end else begin
            dx     <= dx_n;
            dy     <= dy_n;
            ball_x <= bx_n;
            ball_y <= by_n;
          end
        end
        OVER: begin
          ball_x <= BALL_X0;
          ball_y <= BALL_Y0;
        end
        default: state <= SERVE;
      endcase
    end
  end

  // Object hit tests and colour priority for the current pixel.
  always_comb begin
    ball_on = in_span(x, ball_x, 11'(BALL_SZ)) && in_span(y, ball_y, 11'(BALL_SZ));
    lp_on   = in_span(x, 10'(PL_X), 11'(PADDLE_W)) && in_span(y, pl_y, 11'(PADDLE_H));
    rp_on   = in_span(x, 10'(PR_X), 11'(PADDLE_W)) && in_span(y, pr_y, 11'(PADDLE_H));
    pix = COL_BLACK;
    if (!video_on)    pix = COL_BLACK;
    else if (ball_on) pix = COL_BALL;
    else if (lp_on)   pix = COL_LEFT;
    else if (rp_on)   pix = COL_RIGHT;
  end

  // Output stage: colour and syncs registered together so they stay aligned.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      rgb       <= COL_BLACK;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= pix;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_pong_game_pixel_gen.sv
// Directed bench for pong_game_pixel_gen: frames are driven as single tick cycles, expectations hand-computed.
module tb_pong_game_pixel_gen;
  import pong_pkg::*;

  logic        clk_25MHz = 1'b0;
  logic        reset = 1'b0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  x = 10'd1;
  logic [9:0]  y = 10'd0;
  logic        btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  int errors = 0;
  int checks = 0;
  int ticks  = 0;

  pong_game_pixel_gen dut (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .video_on  (video_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .x         (x),
    .y         (y),
    .btn_l_up  (btn_l_up),
    .btn_l_dn  (btn_l_dn),
    .btn_r_up  (btn_r_up),
    .btn_r_dn  (btn_r_dn),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  // One frame tick per iteration: a single cycle at (0,VD), then back to a neutral position.
  task automatic frame_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25MHz);
      x = 10'd0;
      y = 10'(VD);
      @(negedge clk_25MHz);
      x = 10'd1;
      y = 10'd0;
      ticks++;
    end
  endtask

  task automatic run_to(input int t);
    frame_ticks(t - ticks);
  endtask

  // Change buttons, then give the synchronizers time to settle before the next tick.
  task automatic set_buttons(input logic lu, input logic ld, input logic ru, input logic rd);
    @(negedge clk_25MHz);
    btn_l_up = lu;
    btn_l_dn = ld;
    btn_r_up = ru;
    btn_r_dn = rd;
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge clk_25MHz);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    ticks = 0;
    idle(1);
  endtask

  task automatic check_ball(input string tag, input int ex, input int ey);
    check({tag, ".ball_x"}, 16'(dut.ball_x), 16'(ex));
    check({tag, ".ball_y"}, 16'(dut.ball_y), 16'(ey));
  endtask

  task automatic pixel(input string tag, input logic vo, input int px, input int py,
                       input logic hs, input logic vs, input logic [11:0] exp_rgb);
    @(negedge clk_25MHz);
    video_on = vo;
    x        = 10'(px);
    y        = 10'(py);
    hsync_in = hs;
    vsync_in = vs;
    @(negedge clk_25MHz);
    check({tag, ".rgb"}, 16'(rgb), 16'(exp_rgb));
    check({tag, ".hsync"}, 16'(hsync_out), 16'(hs));
    check({tag, ".vsync"}, 16'(vsync_out), 16'(vs));
    video_on = 1'b0;
    x        = 10'd1;
    y        = 10'd0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset state, sampled between clock edges.
    #5 reset = 1'b1;
    #5;
    check("rst.rgb", 16'(rgb), 16'h000);
    check("rst.hsync", 16'(hsync_out), 16'd1);
    check("rst.vsync", 16'(vsync_out), 16'd1);
    check("rst.score_l", 16'(score_l), 16'd0);
    check("rst.score_r", 16'(score_r), 16'd0);
    check("rst.game_over", 16'(game_over), 16'd0);
    idle(2);
    reset = 1'b0;
    idle(1);

    // ---- Scenario 1: untouched paddles, repeated right misses up to game over ----
    frame_ticks(1);
    check("t1.pl_y", 16'(dut.pl_y), 16'd204);
    check("t1.pr_y", 16'(dut.pr_y), 16'd204);
    check_ball("t1", 316, 236);
    check("t1.state", 16'(dut.state), 16'(SERVE));
    check("t1.rgb", 16'(rgb), 16'h000);
    run_to(59);
    check("t59.state", 16'(dut.state), 16'(SERVE));
    run_to(60);
    check("t60.state", 16'(dut.state), 16'(PLAY));
    check_ball("t60", 316, 236);
    run_to(61);
    check_ball("t61", 318, 238);
    run_to(177);
    check_ball("t177", 550, 470);
    check("t177.dy", 16'(dut.dy), 16'd1);
    run_to(178);
    check_ball("t178_bottom", 552, 468);
    check("t178.dy", 16'(dut.dy), 16'd0);
    run_to(217);
    check("t217.ball_x", 16'(dut.ball_x), 16'd630);
    check("t217.score_l", 16'(score_l), 16'd0);
    run_to(218);
    check("rmiss.score_l", 16'(score_l), 16'd1);
    check("rmiss.score_r", 16'(score_r), 16'd0);
    check_ball("rmiss", 316, 236);
    check("rmiss.dx", 16'(dut.dx), 16'd1);
    check("rmiss.state", 16'(dut.state), 16'(SERVE));
    run_to(395);
    check_ball("t395", 550, 2);
    check("t395.dy", 16'(dut.dy), 16'd0);
    run_to(396);
    check_ball("top_wall", 552, 4);
    check("top_wall.dy", 16'(dut.dy), 16'd1);
    run_to(1744);
    check("r8.score_l", 16'(score_l), 16'd8);
    check("r8.game_over", 16'(game_over), 16'd0);
    check("r8.state", 16'(dut.state), 16'(SERVE));
    run_to(1962);
    check("win.score_l", 16'(score_l), 16'd9);
    check("win.score_r", 16'(score_r), 16'd0);
    check("win.game_over", 16'(game_over), 16'd1);
    check("win.state", 16'(dut.state), 16'(OVER));
    check_ball("win", 316, 236);
    set_buttons(1'b1, 1'b0, 1'b0, 1'b1);
    frame_ticks(5);
    check("over.pl_y", 16'(dut.pl_y), 16'd204);
    check("over.pr_y", 16'(dut.pr_y), 16'd204);
    check("over.game_over", 16'(game_over), 16'd1);
    check_ball("over", 316, 236);

    // Pixel path with ball at (316,236) and both paddles at row 204.
    pixel("px_ball", 1'b1, 316, 236, 1'b0, 1'b1, 12'hFFF);
    pixel("px_ball_corner", 1'b1, 323, 243, 1'b1, 1'b0, 12'hFFF);
    pixel("px_ball_right_edge", 1'b1, 324, 236, 1'b1, 1'b1, 12'h000);
    pixel("px_blank", 1'b0, 316, 236, 1'b0, 1'b0, 12'h000);
    pixel("px_lpad", 1'b1, 32, 204, 1'b1, 1'b1, 12'h0F0);
    pixel("px_lpad_corner", 1'b1, 35, 275, 1'b1, 1'b1, 12'h0F0);
    pixel("px_lpad_xout", 1'b1, 36, 204, 1'b1, 1'b1, 12'h000);
    pixel("px_lpad_yout", 1'b1, 32, 276, 1'b1, 1'b1, 12'h000);
    pixel("px_rpad", 1'b1, 604, 250, 1'b1, 1'b1, 12'h00F);
    pixel("px_rpad_corner", 1'b1, 607, 204, 1'b1, 1'b1, 12'h00F);
    pixel("px_rpad_xout", 1'b1, 608, 250, 1'b1, 1'b1, 12'h000);

    // ---- Scenario 2: paddle saturation, cancelling buttons, right hit then left hit ----
    do_reset();
    check("rst2.game_over", 16'(game_over), 16'd0);
    check("rst2.score_l", 16'(score_l), 16'd0);
    check("rst2.state", 16'(dut.state), 16'(SERVE));
    set_buttons(1'b1, 1'b0, 1'b0, 1'b1);
    run_to(50);
    check("t50.pl_y", 16'(dut.pl_y), 16'd4);
    check("t50.pr_y", 16'(dut.pr_y), 16'd404);
    run_to(51);
    check("t51.pl_y", 16'(dut.pl_y), 16'd0);
    check("t51.pr_y", 16'(dut.pr_y), 16'd408);
    run_to(60);
    check("t60s.pl_y", 16'(dut.pl_y), 16'd0);
    check("t60s.pr_y", 16'(dut.pr_y), 16'd408);
    set_buttons(1'b0, 1'b1, 1'b0, 1'b1);
    run_to(85);
    check("t85.pl_y", 16'(dut.pl_y), 16'd100);
    set_buttons(1'b1, 1'b1, 1'b0, 1'b1);
    run_to(88);
    check("both.pl_y", 16'(dut.pl_y), 16'd100);
    set_buttons(1'b0, 1'b0, 1'b0, 1'b1);
    run_to(200);
    check_ball("t200", 596, 424);
    check("t200.dx", 16'(dut.dx), 16'd1);
    run_to(201);
    check_ball("rhit", 594, 422);
    check("rhit.dx", 16'(dut.dx), 16'd0);
    run_to(480);
    check_ball("t480", 36, 140);
    check("t480.dx", 16'(dut.dx), 16'd0);
    run_to(481);
    check_ball("lhit", 38, 142);
    check("lhit.dx", 16'(dut.dx), 16'd1);
    check("lhit.score_l", 16'(score_l), 16'd0);
    check("lhit.score_r", 16'(score_r), 16'd0);

    // ---- Scenario 3: left paddle parked at the top, ball runs past it ----
    do_reset();
    set_buttons(1'b1, 1'b0, 1'b0, 1'b1);
    run_to(497);
    check_ball("t497", 2, 174);
    check("t497.pl_y", 16'(dut.pl_y), 16'd0);
    run_to(498);
    check("lmiss.score_r", 16'(score_r), 16'd1);
    check("lmiss.score_l", 16'(score_l), 16'd0);
    check_ball("lmiss", 316, 236);
    check("lmiss.dx", 16'(dut.dx), 16'd0);
    check("lmiss.state", 16'(dut.state), 16'(SERVE));

    // Reset in mid-game returns everything at once.
    run_to(520);
    @(negedge clk_25MHz);
    reset = 1'b1;
    #1;
    check("midrst.score_r", 16'(score_r), 16'd0);
    check("midrst.pl_y", 16'(dut.pl_y), 16'd204);
    check("midrst.dx", 16'(dut.dx), 16'd1);
    idle(2);
    reset = 1'b0;
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
